// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_END     = 3'b111;

  // Watchdog counter width; a disabled watchdog still gets one bit so the
  // counter declaration stays legal.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_arbiter_rr_picker #(
  parameter  int unsigned NUM_MASTERS = 2,
  localparam int unsigned IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IW-1:0]          win_idx,
  output logic                   valid
);

  // Scan last+1 .. last+NUM_MASTERS (mod NUM_MASTERS); the first hit wins.
  always_comb begin
    int unsigned k;
    logic [IW-1:0] kk;
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    k       = 0;
    kk      = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      k  = (32'(last) + i) % NUM_MASTERS;
      kk = IW'(k);
      if (!valid && req[kk]) begin
        valid      = 1'b1;
        winner[kk] = 1'b1;
        win_idx    = kk;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing one slave between several masters,
// with a watchdog that aborts stalled cycles with ERR.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS-1:0]       m_cyc,
  input  logic [NUM_MASTERS-1:0]       m_stb,
  input  logic [NUM_MASTERS-1:0]       m_we,
  input  logic [NUM_MASTERS-1:0][31:0] m_adr,
  input  logic [NUM_MASTERS-1:0][31:0] m_dat,
  input  logic [NUM_MASTERS-1:0][2:0]  m_cti,
  output logic [NUM_MASTERS-1:0]       m_ack,
  output logic [NUM_MASTERS-1:0]       m_err,
  output logic [NUM_MASTERS-1:0]       m_rty,
  output logic [31:0]                  m_dat_i,
  output logic [NUM_MASTERS-1:0]       gnt,
  output logic                         CYC,
  output logic                         STB,
  output logic                         WE,
  output logic [31:0]                  ADR,
  output logic [31:0]                  DAT_O,
  output logic [2:0]                   CTI_O,
  input  logic                         ACK,
  input  logic                         ERR,
  input  logic                         RTY,
  input  logic [31:0]                  DAT_I
);

  localparam int unsigned IW  = $clog2(NUM_MASTERS);
  localparam int unsigned WDW = wdog_width(TIMEOUT);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          last;
  logic [WDW-1:0]         wdog;

  logic [NUM_MASTERS-1:0] pick_win;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   stall;
  logic                   wd_fire;

  wb_arbiter_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req     (m_cyc),
    .last    (last),
    .winner  (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign stall   = STB & ~(ACK | ERR | RTY);
  assign wd_fire = (TIMEOUT != 0) && stall && (wdog == WD_MAX);
  assign gnt     = gnt_q;
  assign m_dat_i = DAT_I;

  // Arbitration FSM with grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      gnt_q <= '0;
      gidx  <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      wdog  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            state <= ARB_GRANT;
            gnt_q <= pick_win;
            gidx  <= pick_idx;
          end
        end
        ARB_GRANT: begin
          if (!m_cyc[gidx]) begin
            state <= ARB_IDLE;
            last  <= gidx;
            gnt_q <= '0;
            wdog  <= '0;
          end else if (wd_fire) begin
            state <= ARB_ABORT;
            wdog  <= '0;
          end else if (stall) begin
            if (wdog != WD_MAX) wdog <= wdog + WDW'(1);
          end else begin
            wdog <= '0;
          end
        end
        ARB_ABORT: begin
          state <= ARB_IDLE;
          last  <= gidx;
          gnt_q <= '0;
          wdog  <= '0;
        end
        default: begin
          state <= ARB_IDLE;
          gnt_q <= '0;
          wdog  <= '0;
        end
      endcase
    end
  end

  // Route the granted master to the slave and the slave response back to it.
  always_comb begin
    CYC   = 1'b0;
    STB   = 1'b0;
    WE    = 1'b0;
    ADR   = '0;
    DAT_O = '0;
    CTI_O = '0;
    m_ack = '0;
    m_err = '0;
    m_rty = '0;
    if (state == ARB_GRANT) begin
      CYC         = m_cyc[gidx];
      STB         = m_cyc[gidx] & m_stb[gidx];
      WE          = m_we[gidx];
      ADR         = m_adr[gidx];
      DAT_O       = m_dat[gidx];
      CTI_O       = m_cti[gidx];
      m_ack[gidx] = ACK;
      m_err[gidx] = ERR;
      m_rty[gidx] = RTY;
    end else if (state == ARB_ABORT) begin
      m_err[gidx] = 1'b1;
    end
  end

endmodule
